// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT post-processing blocks: the complex
// sample layout, the power word width and the bin-index width helper.
package fft_pkg;

   localparam int CPLX_WIDTH  = 16;
   localparam int POWER_WIDTH = 2 * CPLX_WIDTH;

   typedef struct packed {
      logic signed [CPLX_WIDTH-1:0] re;
      logic signed [CPLX_WIDTH-1:0] im;
   } complex_t;

   function automatic int bin_width(input int fft_size);
      return $clog2(fft_size);
   endfunction

endpackage

// File: rtl/fft_cplx_sq.sv
// First pipeline stage: registers re^2 and im^2 of one complex sample together
// with its bin tag. Shifts only on advance; flush drops the held sample.
module fft_cplx_sq #(
   parameter int DW = 16,
   parameter int BW = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic                   advance_i,
   input  logic                   in_valid_i,
   input  logic signed [DW-1:0]   re_i,
   input  logic signed [DW-1:0]   im_i,
   input  logic [BW-1:0]          bin_i,
   output logic                   valid_o,
   output logic signed [2*DW-1:0] re_sq_o,
   output logic signed [2*DW-1:0] im_sq_o,
   output logic [BW-1:0]          bin_o
);

   logic                   valid_q, valid_d;
   logic signed [2*DW-1:0] re_sq_q, re_sq_d;
   logic signed [2*DW-1:0] im_sq_q, im_sq_d;
   logic signed [2*DW-1:0] re_ext, im_ext;
   logic [BW-1:0]          bin_q, bin_d;

   always_comb begin
      re_ext  = {{DW{re_i[DW-1]}}, re_i};
      im_ext  = {{DW{im_i[DW-1]}}, im_i};
      valid_d = valid_q;
      re_sq_d = re_sq_q;
      im_sq_d = im_sq_q;
      bin_d   = bin_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (advance_i) begin
         valid_d = in_valid_i;
         if (in_valid_i) begin
            // Squares of a sign-extended Q1.15 value never exceed 2^30.
            re_sq_d = re_ext * re_ext;
            im_sq_d = im_ext * im_ext;
            bin_d   = bin_i;
         end else begin
            bin_d = bin_q;
         end
      end else begin
         valid_d = valid_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         re_sq_q <= '0;
         im_sq_q <= '0;
         bin_q   <= '0;
      end else begin
         valid_q <= valid_d;
         re_sq_q <= re_sq_d;
         im_sq_q <= im_sq_d;
         bin_q   <= bin_d;
      end
   end

   assign valid_o = valid_q;
   assign re_sq_o = re_sq_q;
   assign im_sq_o = im_sq_q;
   assign bin_o   = bin_q;

endmodule

// File: rtl/fft_power_peak.sv
// Converts a stream of FFT bins to power (re^2+im^2) with a two-stage
// back-pressured pipeline, and reports the per-frame peak bin and power.
module fft_power_peak
   import fft_pkg::*;
#(
   parameter int FFT_SIZE      = 16,
   parameter int DATA_WIDTH    = CPLX_WIDTH,
   parameter int HALF_SPECTRUM = 1
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        clear_i,
   input  logic                        in_valid_i,
   input  logic [2*DATA_WIDTH-1:0]     in_data_i,
   output logic                        in_ready_o,
   output logic                        pwr_valid_o,
   output logic [2*DATA_WIDTH-1:0]     pwr_data_o,
   output logic [$clog2(FFT_SIZE)-1:0] pwr_bin_o,
   output logic                        pwr_last_o,
   input  logic                        pwr_ready_i,
   output logic                        peak_valid_o,
   output logic [$clog2(FFT_SIZE)-1:0] peak_bin_o,
   output logic [2*DATA_WIDTH-1:0]     peak_pwr_o,
   output logic [15:0]                 frame_cnt_o
);

   localparam int DW       = DATA_WIDTH;
   localparam int PW       = 2 * DATA_WIDTH;
   localparam int BW       = bin_width(FFT_SIZE);
   localparam int OUT_BINS = (HALF_SPECTRUM != 0) ? FFT_SIZE / 2 : FFT_SIZE;
   localparam logic [BW-1:0] LAST_BIN = BW'(OUT_BINS - 1);

   logic                 advance, in_hs, out_hs, admit, take;
   logic                 s1_valid;
   logic signed [PW-1:0] s1_re_sq, s1_im_sq;
   logic [BW-1:0]        s1_bin;
   logic [BW-1:0]        bin_cnt_q, bin_cnt_d;
   logic                 pwr_valid_q, pwr_valid_d, pwr_last_q, pwr_last_d;
   logic [PW-1:0]        pwr_data_q, pwr_data_d;
   logic [BW-1:0]        pwr_bin_q, pwr_bin_d;
   logic [PW-1:0]        max_pwr_q, max_pwr_d, cand_pwr;
   logic [BW-1:0]        max_bin_q, max_bin_d, cand_bin;
   logic                 peak_valid_q, peak_valid_d;
   logic [BW-1:0]        peak_bin_q, peak_bin_d;
   logic [PW-1:0]        peak_pwr_q, peak_pwr_d;
   logic [15:0]          frame_cnt_q, frame_cnt_d;

   always_comb begin
      advance    = !pwr_valid_q || pwr_ready_i;
      in_ready_o = advance && !clear_i;
      in_hs      = in_valid_i && in_ready_o;
      out_hs     = pwr_valid_q && pwr_ready_i;
      // Upper-half bins are consumed but become bubbles in the pipeline.
      admit      = in_hs && ((HALF_SPECTRUM == 0) || !bin_cnt_q[BW-1]);
   end

   fft_cplx_sq #(.DW(DW), .BW(BW)) u_sq (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .flush_i    (clear_i),
      .advance_i  (advance),
      .in_valid_i (admit),
      .re_i       (in_data_i[PW-1:DW]),
      .im_i       (in_data_i[DW-1:0]),
      .bin_i      (bin_cnt_q),
      .valid_o    (s1_valid),
      .re_sq_o    (s1_re_sq),
      .im_sq_o    (s1_im_sq),
      .bin_o      (s1_bin)
   );

   always_comb begin
      bin_cnt_d    = bin_cnt_q;
      pwr_valid_d  = pwr_valid_q;
      pwr_data_d   = pwr_data_q;
      pwr_bin_d    = pwr_bin_q;
      pwr_last_d   = pwr_last_q;
      max_pwr_d    = max_pwr_q;
      max_bin_d    = max_bin_q;
      peak_valid_d = 1'b0;
      peak_bin_d   = peak_bin_q;
      peak_pwr_d   = peak_pwr_q;
      frame_cnt_d  = frame_cnt_q;

      take     = (pwr_bin_q == '0) || (pwr_data_q > max_pwr_q);
      cand_pwr = take ? pwr_data_q : max_pwr_q;
      cand_bin = take ? pwr_bin_q : max_bin_q;

      if (clear_i) begin
         bin_cnt_d   = '0;
         pwr_valid_d = 1'b0;
         max_pwr_d   = '0;
         max_bin_d   = '0;
      end else begin
         if (in_hs) begin
            bin_cnt_d = bin_cnt_q + BW'(1);
         end else begin
            bin_cnt_d = bin_cnt_q;
         end
         if (advance) begin
            pwr_valid_d = s1_valid;
            if (s1_valid) begin
               // Both squares are non-negative, so the unsigned sum holds 2^31.
               pwr_data_d = $unsigned(s1_re_sq) + $unsigned(s1_im_sq);
               pwr_bin_d  = s1_bin;
               pwr_last_d = (s1_bin == LAST_BIN);
            end else begin
               pwr_last_d = pwr_last_q;
            end
         end else begin
            pwr_valid_d = pwr_valid_q;
         end
         if (out_hs) begin
            max_pwr_d = cand_pwr;
            max_bin_d = cand_bin;
            if (pwr_last_q) begin
               peak_valid_d = 1'b1;
               peak_bin_d   = cand_bin;
               peak_pwr_d   = cand_pwr;
               frame_cnt_d  = frame_cnt_q + 16'd1;
            end else begin
               peak_valid_d = 1'b0;
            end
         end else begin
            max_pwr_d = max_pwr_q;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bin_cnt_q    <= '0;
         pwr_valid_q  <= 1'b0;
         pwr_data_q   <= '0;
         pwr_bin_q    <= '0;
         pwr_last_q   <= 1'b0;
         max_pwr_q    <= '0;
         max_bin_q    <= '0;
         peak_valid_q <= 1'b0;
         peak_bin_q   <= '0;
         peak_pwr_q   <= '0;
         frame_cnt_q  <= '0;
      end else begin
         bin_cnt_q    <= bin_cnt_d;
         pwr_valid_q  <= pwr_valid_d;
         pwr_data_q   <= pwr_data_d;
         pwr_bin_q    <= pwr_bin_d;
         pwr_last_q   <= pwr_last_d;
         max_pwr_q    <= max_pwr_d;
         max_bin_q    <= max_bin_d;
         peak_valid_q <= peak_valid_d;
         peak_bin_q   <= peak_bin_d;
         peak_pwr_q   <= peak_pwr_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign pwr_valid_o  = pwr_valid_q;
   assign pwr_data_o   = pwr_data_q;
   assign pwr_bin_o    = pwr_bin_q;
   assign pwr_last_o   = pwr_last_q;
   assign peak_valid_o = peak_valid_q;
   assign peak_bin_o   = peak_bin_q;
   assign peak_pwr_o   = peak_pwr_q;
   assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_fft_power_peak.sv
// Directed bench for fft_power_peak: a half-spectrum instance for most
// scenarios and a full-spectrum instance for back-to-back frames.
module tb_fft_power_peak;
   import fft_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        clr_h, v_h, prdy_h, ir_h, pv_h, pl_h, pkv_h;
   logic [31:0] d_h, pd_h, pkp_h;
   logic [3:0]  pb_h, pkb_h;
   logic [15:0] fc_h;
   logic        clr_f, v_f, prdy_f, ir_f, pv_f, pl_f, pkv_f;
   logic [31:0] d_f, pd_f, pkp_f;
   logic [3:0]  pb_f, pkb_f;
   logic [15:0] fc_f;

   fft_power_peak #(.FFT_SIZE(16), .DATA_WIDTH(16), .HALF_SPECTRUM(1)) dut_h (
      .clk_i(clk), .rst_i(rst), .clear_i(clr_h), .in_valid_i(v_h), .in_data_i(d_h),
      .in_ready_o(ir_h), .pwr_valid_o(pv_h), .pwr_data_o(pd_h), .pwr_bin_o(pb_h),
      .pwr_last_o(pl_h), .pwr_ready_i(prdy_h), .peak_valid_o(pkv_h),
      .peak_bin_o(pkb_h), .peak_pwr_o(pkp_h), .frame_cnt_o(fc_h));

   fft_power_peak #(.FFT_SIZE(16), .DATA_WIDTH(16), .HALF_SPECTRUM(0)) dut_f (
      .clk_i(clk), .rst_i(rst), .clear_i(clr_f), .in_valid_i(v_f), .in_data_i(d_f),
      .in_ready_o(ir_f), .pwr_valid_o(pv_f), .pwr_data_o(pd_f), .pwr_bin_o(pb_f),
      .pwr_last_o(pl_f), .pwr_ready_i(prdy_f), .peak_valid_o(pkv_f),
      .peak_bin_o(pkb_f), .peak_pwr_o(pkp_f), .frame_cnt_o(fc_f));

   int checks = 0;
   int failures = 0;

   logic [31:0] qp_h[$];
   logic [3:0]  qb_h[$];
   logic        ql_h[$];
   logic [31:0] qp_f[$];
   logic [3:0]  qb_f[$];
   logic        ql_f[$];
   int          npk_h = 0;
   int          npk_f = 0;
   logic        stall_prev = 1'b0;
   logic [31:0] sp_d;
   logic [3:0]  sp_b;
   logic        sp_l;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Output monitor: records handshakes, counts peak pulses, checks stall stability.
   always @(negedge clk) begin
      if (stall_prev) begin
         chk("hold_data", 64'(pd_h), 64'(sp_d));
         chk("hold_bin", 64'(pb_h), 64'(sp_b));
         chk("hold_last", 64'(pl_h), 64'(sp_l));
      end
      stall_prev <= pv_h && !prdy_h && !rst && !clr_h;
      sp_d <= pd_h;
      sp_b <= pb_h;
      sp_l <= pl_h;
      if (pv_h && prdy_h && !clr_h && !rst) begin
         qp_h.push_back(pd_h);
         qb_h.push_back(pb_h);
         ql_h.push_back(pl_h);
      end
      if (pv_f && prdy_f && !clr_f && !rst) begin
         qp_f.push_back(pd_f);
         qb_f.push_back(pb_f);
         ql_f.push_back(pl_f);
      end
      if (pkv_h) npk_h <= npk_h + 1;
      if (pkv_f) npk_f <= npk_f + 1;
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_h(input logic [15:0] re, input logic [15:0] im);
      int t;
      complex_t c;
      c.re = re;
      c.im = im;
      v_h = 1'b1;
      d_h = c;
      t = 0;
      @(negedge clk);
      while (!ir_h && t < 100) begin
         t++;
         @(negedge clk);
      end
      if (t >= 100) begin
         checks++;
         failures++;
         $error("FAIL send_h_timeout observed=%0d expected=<100", t);
      end
      @(posedge clk);
      #1;
      v_h = 1'b0;
   endtask

   task automatic send_f(input logic [15:0] re, input logic [15:0] im);
      int t;
      v_f = 1'b1;
      d_f = {re, im};
      t = 0;
      @(negedge clk);
      while (!ir_f && t < 100) begin
         t++;
         @(negedge clk);
      end
      if (t >= 100) begin
         checks++;
         failures++;
         $error("FAIL send_f_timeout observed=%0d expected=<100", t);
      end
      @(posedge clk);
      #1;
      v_f = 1'b0;
   endtask

   task automatic flush_q();
      qp_h.delete(); qb_h.delete(); ql_h.delete();
   endtask

   initial begin
      int pk0;
      rst = 1'b1;
      clr_h = 1'b0; v_h = 1'b0; d_h = 32'h0; prdy_h = 1'b1;
      clr_f = 1'b0; v_f = 1'b0; d_f = 32'h0; prdy_f = 1'b1;
      idle(3);

      // Reset state
      chk("rst_pwr_valid", 64'(pv_h), 64'd0);
      chk("rst_pwr_data", 64'(pd_h), 64'd0);
      chk("rst_pwr_bin", 64'(pb_h), 64'd0);
      chk("rst_pwr_last", 64'(pl_h), 64'd0);
      chk("rst_peak_valid", 64'(pkv_h), 64'd0);
      chk("rst_peak_bin", 64'(pkb_h), 64'd0);
      chk("rst_peak_pwr", 64'(pkp_h), 64'd0);
      chk("rst_frame_cnt", 64'(fc_h), 64'd0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 64'(ir_h), 64'd1);

      // Mid-frame reset discards the partial frame
      for (int i = 0; i < 5; i++) send_h(16'h7000, 16'h0);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(3);
      chk("midrst_peaks", 64'(npk_h), 64'd0);
      chk("midrst_pwr_valid", 64'(pv_h), 64'd0);
      chk("midrst_frame_cnt", 64'(fc_h), 64'd0);
      chk("midrst_peak_pwr", 64'(pkp_h), 64'd0);
      flush_q();

      // Single tone at bin 3
      pk0 = npk_h;
      for (int i = 0; i < 16; i++) send_h((i == 3) ? 16'h4000 : 16'h0000, 16'h0);
      idle(4);
      chk("tone_count", 64'(qp_h.size()), 64'd8);
      for (int i = 0; i < 8; i++) begin
         chk("tone_bin", 64'(qb_h[i]), 64'(i));
         chk("tone_pwr", 64'(qp_h[i]), (i == 3) ? 64'h1000_0000 : 64'h0);
         chk("tone_last", 64'(ql_h[i]), (i == 7) ? 64'd1 : 64'd0);
      end
      chk("tone_peak_bin", 64'(pkb_h), 64'd3);
      chk("tone_peak_pwr", 64'(pkp_h), 64'h1000_0000);
      chk("tone_peak_pulses", 64'(npk_h - pk0), 64'd1);
      chk("tone_frame_cnt", 64'(fc_h), 64'd1);
      flush_q();

      // Full-scale negative sample: 2^31 without wrap, 2-cycle latency
      pk0 = npk_h;
      send_h(16'h8000, 16'h8000);
      chk("lat_not_yet", 64'(pv_h), 64'd0);
      idle(1);
      chk("lat_valid", 64'(pv_h), 64'd1);
      chk("max_pwr_data", 64'(pd_h), 64'h8000_0000);
      for (int i = 1; i < 16; i++) send_h(16'h0, 16'h0);
      idle(4);
      chk("max_count", 64'(qp_h.size()), 64'd8);
      chk("max_peak_bin", 64'(pkb_h), 64'd0);
      chk("max_peak_pwr", 64'(pkp_h), 64'h8000_0000);
      chk("max_frame_cnt", 64'(fc_h), 64'd2);
      flush_q();

      // Equal powers at bins 2 and 5: lower bin wins
      for (int i = 0; i < 16; i++)
         send_h((i == 2 || i == 5) ? 16'h0010 : 16'h0000, 16'h0);
      idle(4);
      chk("tie_pwr5", 64'(qp_h[5]), 64'h100);
      chk("tie_peak_bin", 64'(pkb_h), 64'd2);
      chk("tie_peak_pwr", 64'(pkp_h), 64'h100);
      chk("tie_frame_cnt", 64'(fc_h), 64'd3);
      flush_q();

      // Back-pressure for 5 cycles in the middle of a ramp frame
      fork
         begin
            for (int i = 0; i < 16; i++) send_h(16'(i * 256), 16'h0);
         end
         begin
            idle(5);
            prdy_h = 1'b0;
            idle(2);
            chk("stall_in_ready", 64'(ir_h), 64'd0);
            chk("stall_pwr_valid", 64'(pv_h), 64'd1);
            idle(3);
            prdy_h = 1'b1;
         end
      join
      idle(4);
      chk("stall_count", 64'(qp_h.size()), 64'd8);
      for (int i = 0; i < 8; i++) begin
         chk("stall_bin", 64'(qb_h[i]), 64'(i));
         chk("stall_pwr", 64'(qp_h[i]), 64'(i * i * 65536));
      end
      chk("stall_peak_bin", 64'(pkb_h), 64'd7);
      chk("stall_peak_pwr", 64'(pkp_h), 64'h31_0000);
      chk("stall_frame_cnt", 64'(fc_h), 64'd4);
      flush_q();

      // Clear at bin 6, then a fresh frame
      pk0 = npk_h;
      for (int i = 0; i < 6; i++) send_h(16'h7000, 16'h0);
      clr_h = 1'b1;
      v_h = 1'b1;
      d_h = {16'h7000, 16'h0000};
      @(negedge clk);
      chk("clr_in_ready", 64'(ir_h), 64'd0);
      @(posedge clk);
      #1;
      clr_h = 1'b0;
      v_h = 1'b0;
      flush_q();
      idle(3);
      chk("clr_flushed", 64'(pv_h), 64'd0);
      chk("clr_frame_cnt", 64'(fc_h), 64'd4);
      chk("clr_no_peak", 64'(npk_h - pk0), 64'd0);
      for (int i = 0; i < 16; i++) send_h((i == 4) ? 16'h0100 : 16'h0000, 16'h0);
      idle(4);
      chk("clr_count", 64'(qp_h.size()), 64'd8);
      chk("clr_first_bin", 64'(qb_h[0]), 64'd0);
      chk("clr_peak_pulses", 64'(npk_h - pk0), 64'd1);
      chk("clr_peak_bin", 64'(pkb_h), 64'd4);
      chk("clr_peak_pwr", 64'(pkp_h), 64'h1_0000);
      chk("clr_frame_cnt_after", 64'(fc_h), 64'd5);
      flush_q();

      // Full spectrum, three frames back to back
      for (int f = 0; f < 3; f++)
         for (int i = 0; i < 16; i++) send_f(16'(i * 256), 16'h0);
      idle(4);
      chk("full_count", 64'(qp_f.size()), 64'd48);
      for (int i = 0; i < 48; i++) begin
         chk("full_bin", 64'(qb_f[i]), 64'(i % 16));
         chk("full_last", 64'(ql_f[i]), ((i % 16) == 15) ? 64'd1 : 64'd0);
         chk("full_pwr", 64'(qp_f[i]), 64'((i % 16) * (i % 16) * 65536));
      end
      chk("full_frame_cnt", 64'(fc_f), 64'd3);
      chk("full_peak_pulses", 64'(npk_f), 64'd3);
      chk("full_peak_bin", 64'(pkb_f), 64'd15);
      chk("full_peak_pwr", 64'(pkp_f), 64'hE1_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fft_power_peak.md
FFT_POWER_PEAK -- requirements
Module: fft_power_peak

Interface
REQ-001 Parameter FFT_SIZE, default 16, meaning points per frame; SHALL be a power of two ≥ 4.
REQ-002 Parameter DATA_WIDTH, default 16, meaning signed Q1.15 width of each re/im component.
REQ-003 Parameter HALF_SPECTRUM, default 1, meaning when 1 only bins 0..FFT_SIZE/2-1 are output.
REQ-004 clk_i  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous and active-high.
REQ-006 clear_i  input  1  synchronous frame restart; flushes pipeline and bin counter.
REQ-007 in_valid_i  input  1  FFT result sample valid.
REQ-008 in_data_i  input  2*DATA_WIDTH  packed {re[2*DW-1:DW], im[DW-1:0]}, signed.
REQ-009 in_ready_o  output  1  block accepts in_data_i.
REQ-010 pwr_valid_o  output  1  power sample valid.
REQ-011 pwr_data_o  output  2*DATA_WIDTH  unsigned re²+im².
REQ-012 pwr_bin_o  output  $clog2(FFT_SIZE)  bin index of pwr_data_o.
REQ-013 pwr_last_o  output  1  marks the final output bin of a frame.
REQ-014 pwr_ready_i  input  1  downstream accepts power sample.
REQ-015 peak_valid_o  output  1  one-cycle pulse: frame peak report valid.
REQ-016 peak_bin_o  output  $clog2(FFT_SIZE)  bin of maximum power in last frame.
REQ-017 peak_pwr_o  output  2*DATA_WIDTH  maximum power of last frame.
REQ-018 frame_cnt_o  output  16  completed-frame count, wraps 0xFFFF->0.

Function
REQ-019 Input handshake occurs when in_valid_i && in_ready_o; output handshake when pwr_valid_o && pwr_ready_i.
REQ-020 Pipeline SHALL be two stages: S1 registers re², im² (each 2*DW signed products); S2 registers their sum; latency input-handshake to pwr_valid_o = 2 cycles.
REQ-021 advance = !pwr_valid_o || pwr_ready_i; both stages SHALL shift only when advance; in_ready_o = advance && !clear_i.
REQ-022 Sum SHALL be computed unsigned in 2*DW bits; max value 2^31 (re=im=-32768) SHALL NOT overflow.
REQ-023 Bin counter SHALL increment on every input handshake, wrap FFT_SIZE-1 -> 0; bin tag travels with data through S1/S2.
REQ-024 With HALF_SPECTRUM=1, samples with bin ≥ FFT_SIZE/2 SHALL be accepted but not enter S1 (bubble); pwr_last_o on bin FFT_SIZE/2-1; else on bin FFT_SIZE-1.
REQ-025 Peak tracker SHALL update on each output handshake: bin 0 loads max unconditionally; later bins replace only if strictly greater (ties keep lower bin).
REQ-026 On the output handshake with pwr_last_o, peak_valid_o SHALL pulse the next cycle with final peak_bin_o/peak_pwr_o, and frame_cnt_o SHALL increment.
REQ-027 peak_bin_o/peak_pwr_o SHALL hold until next peak_valid_o.
REQ-028 pwr_data_o/pwr_bin_o/pwr_last_o SHALL remain stable while pwr_valid_o && !pwr_ready_i.
REQ-029 clear_i SHALL, in the same cycle: invalidate S1/S2, zero bin counter and running max; an input offered that cycle is not accepted; peak outputs and frame_cnt_o retained.
REQ-030 clear_i concurrent with a last-bin output handshake: clear wins; no peak_valid_o, no frame_cnt_o increment.

Reset
REQ-031 rst_i SHALL zero all state: pwr_valid_o=0, pwr_data_o=0, pwr_bin_o=0, pwr_last_o=0, peak_valid_o=0, peak_bin_o=0, peak_pwr_o=0, frame_cnt_o=0, bin counter 0; in_ready_o=1 after reset released.
REQ-032 rst_i asserted mid-frame SHALL discard the partial frame with no peak report.

Structure
REQ-033 complex_t typedef, POWER_WIDTH and bin-width constants SHALL live in shared package fft_pkg, reused by fft_core.
REQ-034 One sub-module fft_cplx_sq (registered re²/im² squaring stage, S1) is natural; no FSM beyond counter/valid bits.

Verification
REQ-035 Frame of 16 samples re=0x4000, im=0 at bin k, 0 elsewhere, ready=1 -> 8 outputs, bin k power 0x10000000, peak_bin=k (k<8), one peak_valid_o pulse, frame_cnt_o=1.
REQ-036 Sample re=im=0x8000 -> pwr_data_o=0x80000000 exactly, no wrap.
REQ-037 pwr_ready_i held low 5 cycles mid-frame -> in_ready_o low after pipeline fills, outputs stable, no sample lost or duplicated.
REQ-038 Equal powers 0x100 at bins 2 and 5 -> peak_bin_o=2.
REQ-039 clear_i at bin 6 then full frame -> first output bin 0, single peak report for new frame, frame_cnt_o unchanged by clear.
REQ-040 HALF_SPECTRUM=0, back-to-back 3 frames -> 48 outputs, pwr_last_o on every bin 15, frame_cnt_o=3.
